vend_ctrl: RTL and testbench
============================

VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 Parameter CREDIT_W, default 8, width of the credit accumulator and change amount.
REQ-002 Parameter PRICE, default 15, product price in credit units; must satisfy 0 < PRICE <= 2**CREDIT_W-1.
REQ-003 Parameters VAL0 / VAL1 / VAL2, defaults 5 / 10 / 25, credit value of coin codes 0 / 1 / 2.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 coin_valid  input  1  one coin presented this cycle.
REQ-007 coin_sel  input  2  coin code; 3 is an illegal code.
REQ-008 cancel  input  1  customer requests refund of current credit.
REQ-009 change_ready  input  1  change dispenser accepts change_amt this cycle.
REQ-010 dispense_prod  output  1  one-cycle product-release pulse.
REQ-011 coin_reject  output  1  one-cycle pulse: the coin presented in the previous cycle was returned and not credited.
REQ-012 change_valid  output  1  change_amt is valid; held until handshake.
REQ-013 change_amt  output  CREDIT_W  change or refund amount.
REQ-014 credit  output  CREDIT_W  current accumulated credit.

Function
REQ-015 All outputs SHALL be registered.
REQ-016 FSM states SHALL be IDLE (credit 0), COLLECT (0 < credit < PRICE), VEND, and CHANGE.
REQ-017 In IDLE/COLLECT, a legal coin SHALL add its value to credit at the next edge, unless credit+value exceeds 2**CREDIT_W-1, in which case the coin is rejected.
REQ-018 coin_sel==3, and any coin_valid in VEND or CHANGE, SHALL be rejected: coin_reject=1 for exactly one cycle, credit unchanged.
REQ-019 When updated credit >= PRICE, next state SHALL be VEND; dispense_prod=1 during the VEND cycle only (latency: pulse in the cycle after the edge that accepted the completing coin).
REQ-020 On leaving VEND, credit SHALL become credit-PRICE; if the remainder is 0, go to IDLE; otherwise go to CHANGE with change_amt=remainder.
REQ-021 cancel in COLLECT SHALL go to CHANGE with change_amt=credit; cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-022 cancel and coin_valid in the same COLLECT cycle: cancel wins, and the coin is rejected.
REQ-023 In CHANGE, change_valid=1 with change_amt stable until the cycle where change_ready=1; at that edge credit:=0, change_valid:=0, next state IDLE.
REQ-024 change_valid SHALL be 0 outside CHANGE; change_amt SHALL be 0 when change_valid=0.
REQ-025 Exactly one dispense_prod pulse per VEND entry; never two consecutive cycles high.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE, credit=0, change_amt=0, and dispense_prod=coin_reject=change_valid=0.
REQ-027 rst asserted mid-VEND or mid-CHANGE SHALL abort with no dispense pulse and no change handshake after release; the credit is lost.
REQ-028 The first state update SHALL occur on the first rising clk edge after rst deasserts.

Structure
REQ-029 Package vend_pkg SHALL hold the state enum (IDLE, COLLECT, VEND, CHANGE) and the coin-code constants (COIN_A=0, COIN_B=1, COIN_C=2, COIN_BAD=3).
REQ-030 Sub-module vend_coin_lut SHALL combinationally map coin_sel to a value/legal flag using VAL0..VAL2; all sequential logic stays in vend_ctrl.

Verification
REQ-031 Defaults; coins 0,0,0 on consecutive cycles -> credit 5,10,15; dispense_prod pulse; credit 0; no change_valid.
REQ-032 Coins 1,1 -> dispense pulse, then change_valid=1, change_amt=5; change_ready low for 3 cycles holds change_amt stable; ready high -> IDLE, credit 0.
REQ-033 Coin 1, then cancel -> change_amt=10 refund, no dispense_prod.
REQ-034 coin_sel=3, and a coin during CHANGE -> coin_reject pulse each, credit unchanged; cancel+coin in the same cycle -> refund, coin rejected.
REQ-035 CREDIT_W=5, credit 25 plus coin 2 (total 50 > 31) -> rejected; credit stays 25.
REQ-036 rst pulsed while change_valid=1 -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// Holds the controller state encoding and the coin-code values.
// No logic lives here.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      CHANGE  = 2'd3
   } state_t;

   localparam logic [1:0] COIN_A   = 2'd0;
   localparam logic [1:0] COIN_B   = 2'd1;
   localparam logic [1:0] COIN_C   = 2'd2;
   localparam logic [1:0] COIN_BAD = 2'd3;

endpackage

// File: rtl/vend_coin_lut.sv
// Coin decoder: maps a coin code to its credit value and a legal flag.
// Purely combinational, zero latency.
// No flow control; the caller decides what to do with an illegal code.
module vend_coin_lut
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8,
   parameter int VAL0     = 5,
   parameter int VAL1     = 10,
   parameter int VAL2     = 25
) (
   input  logic [1:0]          coin_sel,
   output logic [CREDIT_W-1:0] coin_val,
   output logic                coin_legal
);

   // decode the coin code; the unused code reports value 0 and illegal
   always_comb begin
      coin_val   = '0;
      coin_legal = 1'b0;
      case (coin_sel)
         COIN_A: begin
            coin_val   = CREDIT_W'(VAL0);
            coin_legal = 1'b1;
         end
         COIN_B: begin
            coin_val   = CREDIT_W'(VAL1);
            coin_legal = 1'b1;
         end
         COIN_C: begin
            coin_val   = CREDIT_W'(VAL2);
            coin_legal = 1'b1;
         end
         default: begin
            coin_val   = '0;
            coin_legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates coin credit, releases a product, returns change/refunds.
// All outputs registered; a coin's effect is visible one cycle after the accepting edge.
// Change is held on change_valid/change_amt until change_ready; coins arriving meanwhile are rejected.
module vend_ctrl
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8,
   parameter int PRICE    = 15,
   parameter int VAL0     = 5,
   parameter int VAL1     = 10,
   parameter int VAL2     = 25
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                coin_valid,
   input  logic [1:0]          coin_sel,
   input  logic                cancel,
   input  logic                change_ready,
   output logic                dispense_prod,
   output logic                coin_reject,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   output logic [CREDIT_W-1:0] credit
);

   localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_CREDIT = {1'b0, {CREDIT_W{1'b1}}};

   state_t              state;
   state_t              state_n;
   logic [CREDIT_W-1:0] coin_val;
   logic                coin_legal;
   logic [CREDIT_W:0]   credit_sum;
   logic                coin_ok;
   logic                cancel_now;
   logic [CREDIT_W-1:0] credit_n;
   logic [CREDIT_W-1:0] change_amt_n;
   logic                reject_n;
   logic                dispense_n;
   logic                change_valid_n;

   vend_coin_lut #(
      .CREDIT_W (CREDIT_W),
      .VAL0     (VAL0),
      .VAL1     (VAL1),
      .VAL2     (VAL2)
   ) u_coin_lut (
      .coin_sel   (coin_sel),
      .coin_val   (coin_val),
      .coin_legal (coin_legal)
   );

   // one extra bit so an overflowing sum is detectable rather than wrapping
   assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
   assign coin_ok    = coin_valid && coin_legal && (credit_sum <= MAX_CREDIT);
   // a refund only makes sense while some credit is held and nothing is in flight
   assign cancel_now = cancel && (state == COLLECT);

   // state and all outputs are registered together so outputs never glitch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         credit        <= '0;
         change_amt    <= '0;
         dispense_prod <= 1'b0;
         coin_reject   <= 1'b0;
         change_valid  <= 1'b0;
      end else begin
         state         <= state_n;
         credit        <= credit_n;
         change_amt    <= change_amt_n;
         dispense_prod <= dispense_n;
         coin_reject   <= reject_n;
         change_valid  <= change_valid_n;
      end
   end

   // next-state selection: cancel beats a coin, vend lasts exactly one cycle
   always_comb begin
      state_n = state;
      case (state)
         IDLE, COLLECT: begin
            if (cancel_now) begin
               state_n = CHANGE;
            end else if (coin_ok) begin
               if (credit_sum[CREDIT_W-1:0] >= PRICE_C)
                  state_n = VEND;
               else if (credit_sum[CREDIT_W-1:0] == '0)
                  state_n = IDLE;
               else
                  state_n = COLLECT;
            end
         end
         VEND: begin
            state_n = (credit == PRICE_C) ? IDLE : CHANGE;
         end
         CHANGE: begin
            if (change_ready)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // next values of the registered outputs, derived from current state and next state
   always_comb begin
      credit_n     = credit;
      change_amt_n = change_amt;
      reject_n     = 1'b0;
      case (state)
         IDLE, COLLECT: begin
            if (cancel_now) begin
               change_amt_n = credit;
               reject_n     = coin_valid;
            end else if (coin_valid) begin
               if (coin_ok)
                  credit_n = credit_sum[CREDIT_W-1:0];
               else
                  reject_n = 1'b1;
            end
         end
         VEND: begin
            // remainder becomes both the kept credit and the change to pay out
            credit_n     = credit - PRICE_C;
            change_amt_n = credit - PRICE_C;
            reject_n     = coin_valid;
         end
         CHANGE: begin
            reject_n = coin_valid;
            if (change_ready) begin
               credit_n     = '0;
               change_amt_n = '0;
            end
         end
         default: begin
            credit_n     = '0;
            change_amt_n = '0;
         end
      endcase
      dispense_n     = (state_n == VEND);
      change_valid_n = (state_n == CHANGE);
   end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl with a transaction-level model and per-cycle compare.
// A second instance with a narrow credit width covers overflow rejection.
// Inputs are driven on the falling edge; outputs are sampled away from the rising edge.
module tb_vend_ctrl;

   localparam int PRICE = 15;
   localparam int MAXC  = 255;

   typedef struct {
      int credit;
      int chg;
      bit vend;
      bit rej;
   } mstate_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid;
   logic [1:0] coin_sel;
   logic       cancel;
   logic       change_ready;
   logic       dispense_prod;
   logic       coin_reject;
   logic       change_valid;
   logic [7:0] change_amt;
   logic [7:0] credit;

   logic       b_coin_valid;
   logic [1:0] b_coin_sel;
   logic       b_cancel;
   logic       b_change_ready;
   logic       b_dispense_prod;
   logic       b_coin_reject;
   logic       b_change_valid;
   logic [4:0] b_change_amt;
   logic [4:0] b_credit;

   int      checks   = 0;
   int      failures = 0;
   bit      chk_en   = 1'b0;
   mstate_t m        = '{credit: 0, chg: 0, vend: 1'b0, rej: 1'b0};

   vend_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .coin_valid    (coin_valid),
      .coin_sel      (coin_sel),
      .cancel        (cancel),
      .change_ready  (change_ready),
      .dispense_prod (dispense_prod),
      .coin_reject   (coin_reject),
      .change_valid  (change_valid),
      .change_amt    (change_amt),
      .credit        (credit)
   );

   vend_ctrl #(.CREDIT_W(5), .PRICE(30)) dut_narrow (
      .clk           (clk),
      .rst           (rst),
      .coin_valid    (b_coin_valid),
      .coin_sel      (b_coin_sel),
      .cancel        (b_cancel),
      .change_ready  (b_change_ready),
      .dispense_prod (b_dispense_prod),
      .coin_reject   (b_coin_reject),
      .change_valid  (b_change_valid),
      .change_amt    (b_change_amt),
      .credit        (b_credit)
   );

   always #5 clk = ~clk;

   function automatic int coin_value(input logic [1:0] sel);
      case (sel)
         2'd0:    return 5;
         2'd1:    return 10;
         2'd2:    return 25;
         default: return 0;
      endcase
   endfunction

   // transaction view: pending vend, pending change amount, held credit
   function automatic mstate_t model_next(input mstate_t s, input logic cv, input logic [1:0] cs,
                                          input logic cc, input logic cr);
      mstate_t n;
      n     = s;
      n.rej = 1'b0;
      if (s.vend) begin
         n.vend   = 1'b0;
         n.credit = s.credit - PRICE;
         n.chg    = n.credit;
         n.rej    = cv;
      end else if (s.chg != 0) begin
         n.rej = cv;
         if (cr) begin
            n.credit = 0;
            n.chg    = 0;
         end
      end else if (cc && s.credit > 0) begin
         n.chg = s.credit;
         n.rej = cv;
      end else if (cv) begin
         if (cs == 2'd3 || s.credit + coin_value(cs) > MAXC) begin
            n.rej = 1'b1;
         end else begin
            n.credit = s.credit + coin_value(cs);
            n.vend   = (n.credit >= PRICE);
         end
      end
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst)
         m <= '{credit: 0, chg: 0, vend: 1'b0, rej: 1'b0};
      else
         m <= model_next(m, coin_valid, coin_sel, cancel, change_ready);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_credit",       int'(credit),        m.credit);
         chk("cmp_change_amt",   int'(change_amt),    m.chg);
         chk("cmp_change_valid", int'(change_valid),  int'(m.chg != 0));
         chk("cmp_dispense",     int'(dispense_prod), int'(m.vend));
         chk("cmp_coin_reject",  int'(coin_reject),   int'(m.rej));
      end
   end

   task automatic step(input logic cv, input logic [1:0] cs, input logic cc, input logic cr);
      @(negedge clk);
      coin_valid   = cv;
      coin_sel     = cs;
      cancel       = cc;
      change_ready = cr;
      @(posedge clk);
      #1;
   endtask

   task automatic step2(input logic cv, input logic [1:0] cs);
      @(negedge clk);
      b_coin_valid = cv;
      b_coin_sel   = cs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      coin_valid = 0; coin_sel = 0; cancel = 0; change_ready = 0;
      b_coin_valid = 0; b_coin_sel = 0; b_cancel = 0; b_change_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_credit",       int'(credit),        0);
      chk("rst_change_amt",   int'(change_amt),    0);
      chk("rst_change_valid", int'(change_valid),  0);
      chk("rst_dispense",     int'(dispense_prod), 0);
      chk("rst_coin_reject",  int'(coin_reject),   0);
      @(negedge clk);
      rst = 1'b0;

      // three small coins reach the price exactly
      step(1, 0, 0, 0); chk("c5_credit", int'(credit), 5);
      step(1, 0, 0, 0); chk("c10_credit", int'(credit), 10);
      step(1, 0, 0, 0); chk("c15_credit", int'(credit), 15);
      chk("c15_dispense", int'(dispense_prod), 1);
      step(0, 0, 0, 0); chk("c15_after_credit", int'(credit), 0);
      chk("c15_after_dispense", int'(dispense_prod), 0);
      chk("c15_no_change", int'(change_valid), 0);
      step(0, 0, 0, 0);

      // overpay by 5, change held while ready is low
      step(1, 1, 0, 0);
      step(1, 1, 0, 0); chk("c20_dispense", int'(dispense_prod), 1);
      step(0, 0, 0, 0); chk("chg_valid", int'(change_valid), 1);
      chk("chg_amt", int'(change_amt), 5);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0); chk("chg_hold_amt", int'(change_amt), 5);
      end
      step(0, 0, 0, 1); chk("chg_done_valid", int'(change_valid), 0);
      chk("chg_done_credit", int'(credit), 0);
      step(0, 0, 0, 0);

      // refund via cancel
      step(1, 1, 0, 0);
      step(0, 0, 1, 0); chk("refund_amt", int'(change_amt), 10);
      chk("refund_no_dispense", int'(dispense_prod), 0);
      step(0, 0, 0, 1);
      step(0, 0, 1, 0); chk("cancel_idle_ignored", int'(change_valid), 0);

      // illegal code rejected
      step(1, 3, 0, 0); chk("bad_reject", int'(coin_reject), 1);
      chk("bad_credit", int'(credit), 0);
      step(0, 0, 0, 0); chk("bad_reject_pulse", int'(coin_reject), 0);

      // coin while change pending is rejected
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      step(1, 1, 0, 0); chk("chg_coin_reject", int'(coin_reject), 1);
      chk("chg_coin_credit", int'(credit), 5);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);

      // cancel and coin together: refund wins, coin rejected
      step(1, 0, 0, 0);
      step(1, 1, 1, 0); chk("both_amt", int'(change_amt), 5);
      chk("both_reject", int'(coin_reject), 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);

      // coin during vend rejected, change 10 follows
      step(1, 2, 0, 0);
      step(1, 0, 0, 0); chk("vend_coin_reject", int'(coin_reject), 1);
      chk("vend_change_amt", int'(change_amt), 10);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);

      // reset in the middle of a pending refund
      step(1, 1, 0, 0);
      step(0, 0, 1, 0); chk("pre_rst_valid", int'(change_valid), 1);
      @(negedge clk);
      cancel = 0; coin_valid = 0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid",  int'(change_valid), 0);
      chk("rst_mid_amt",    int'(change_amt),   0);
      chk("rst_mid_credit", int'(credit),       0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, 1); chk("post_rst_valid", int'(change_valid), 0);

      // reset during the vend cycle kills the pulse
      step(1, 2, 0, 0); chk("pre_rst_dispense", int'(dispense_prod), 1);
      @(negedge clk);
      coin_valid = 0;
      #2 rst = 1'b1;
      #1;
      chk("rst_vend_dispense", int'(dispense_prod), 0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, 0); chk("post_vend_rst_dispense", int'(dispense_prod), 0);
      chk("post_vend_rst_valid", int'(change_valid), 0);

      // narrow credit width: 25 + 25 overflows 31
      step2(1, 2); chk("n_credit25", int'(b_credit), 25);
      step2(1, 2); chk("n_overflow_reject", int'(b_coin_reject), 1);
      chk("n_overflow_credit", int'(b_credit), 25);
      step2(1, 0); chk("n_vend_dispense", int'(b_dispense_prod), 1);
      step2(0, 0); chk("n_after_credit", int'(b_credit), 0);
      chk("n_after_valid", int'(b_change_valid), 0);

      step(0, 0, 0, 0);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
